// File: rtl/seg7_capture_decoder.sv
// Passive reader for an active-low multiplexed 7-segment bus. It waits until a digit pattern
// is stable, decodes it to a hex nibble plus dot, and stores the result in that digit's slot.
module seg7_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    RST,
  input  logic [7:0]              SEG,
  input  logic [NUM_DIGITS-1:0]   DIG_EN,
  input  logic                    CLR_ERR,
  output logic [4*NUM_DIGITS-1:0] HEX_VAL,
  output logic [NUM_DIGITS-1:0]   DOT,
  output logic [NUM_DIGITS-1:0]   DIG_VALID,
  output logic                    UPDATE,
  output logic [7:0]              UPD_IDX,
  output logic                    ERR
);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [6:0]       BLANK    = 7'h7F;

  state_t                  state;
  logic [7:0]              s_seg;
  logic [NUM_DIGITS-1:0]   s_en;
  logic [7:0]              ref_seg;
  logic [7:0]              ref_idx;
  logic [CNT_W-1:0]        cnt;

  logic                    s_sel;
  logic [7:0]              s_idx;
  logic                    s_match;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    do_commit;
  logic [4:0]              dec;

  // Returns {legal, nibble}; segment bits are active-low g..a.
  function automatic logic [4:0] decode(input logic [6:0] code);
    case (code)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h18:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    s_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!s_en[i]) s_idx = 8'(i);
  end

  assign s_sel   = $onehot(~s_en);
  assign s_match = s_sel && (s_idx == ref_idx) && (s_seg == ref_seg);
  assign cnt_nxt = cnt + CNT_W'(1);
  assign dec     = decode(s_seg[6:0]);

  // A commit always uses the current sample: in TRACK it equals ref, in IDLE ref is not loaded yet.
  always_comb begin
    do_commit = 1'b0;
    case (state)
      IDLE:    do_commit = s_sel && (STABLE_CYCLES == 1);
      TRACK:   do_commit = s_match && (cnt_nxt >= STABLE_N);
      default: do_commit = 1'b0;
    endcase
  end

  // The enable sample idles at all-disabled so a single-digit build never sees a phantom select.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      s_seg <= '0;
      s_en  <= '1;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      s_seg <= SEG;
      s_en  <= DIG_EN;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      ref_seg   <= '0;
      ref_idx   <= '0;
      HEX_VAL   <= '0;
      DOT       <= '0;
      DIG_VALID <= '0;
      UPDATE    <= 1'b0;
      UPD_IDX   <= '0;
      ERR       <= 1'b0;
    end else begin
      UPDATE <= do_commit;

      case (state)
        IDLE: begin
          if (s_sel) begin
            ref_seg <= s_seg;
            ref_idx <= s_idx;
            cnt     <= CNT_W'(1);
            state   <= (STABLE_CYCLES == 1) ? HELD : TRACK;
          end
        end
        default: begin
          if (s_match) begin
            if (state == TRACK) begin
              cnt <= cnt_nxt;
              if (cnt_nxt >= STABLE_N) state <= HELD;
            end
          end else if (s_sel) begin
            // A new pattern or a new digit restarts the episode without committing.
            ref_seg <= s_seg;
            ref_idx <= s_idx;
            cnt     <= CNT_W'(1);
            state   <= TRACK;
          end else begin
            state <= IDLE;
          end
        end
      endcase

      if (do_commit) UPD_IDX <= s_idx;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (do_commit && (s_idx == 8'(i))) begin
          DOT[i]       <= ~s_seg[7];
          DIG_VALID[i] <= dec[4];
          if (dec[4]) HEX_VAL[4*i +: 4] <= dec[3:0];
        end
      end

      // An illegal commit beats a simultaneous clear; blank does not touch ERR.
      if (do_commit && !dec[4] && (s_seg[6:0] != BLANK)) ERR <= 1'b1;
      else if (CLR_ERR)                                  ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder: stimulus pushes expected commits (with their
// cycle), a negedge monitor pops and compares whenever UPDATE is seen.
module tb_seg7_capture_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    seg;
  logic [ND-1:0] dig_en;
  logic          clr_err;
  logic [4*ND-1:0] hex_val;
  logic [ND-1:0] dot;
  logic [ND-1:0] dig_valid;
  logic          update;
  logic [7:0]    upd_idx;
  logic          err;

  seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .SEG      (seg),
    .DIG_EN   (dig_en),
    .CLR_ERR  (clr_err),
    .HEX_VAL  (hex_val),
    .DOT      (dot),
    .DIG_VALID(dig_valid),
    .UPDATE   (update),
    .UPD_IDX  (upd_idx),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks    = 0;
  int failures  = 0;
  int n_updates = 0;

  typedef struct {
    int          at;
    logic [7:0]  idx;
    logic [15:0] hex;
    logic [3:0]  dot;
    logic [3:0]  valid;
    logic        err;
  } exp_t;

  exp_t sb[$];

  logic [15:0] m_hex;
  logic [3:0]  m_dot;
  logic [3:0]  m_valid;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [7:0] s);
    dig_en = en;
    seg    = s;
  endtask

  // kind: 0 = legal, 1 = blank, 2 = illegal. Called in the cycle the pattern is first driven.
  task automatic expect_commit(input int idx, input int kind, input logic [3:0] nib, input logic d);
    exp_t e;
    if (kind == 0) begin
      m_hex[4*idx +: 4] = nib;
      m_valid[idx]      = 1'b1;
    end else begin
      m_valid[idx] = 1'b0;
    end
    if (kind == 2) m_err = 1'b1;
    m_dot[idx] = d;
    e.at    = cyc + SC + 1;
    e.idx   = 8'(idx);
    e.hex   = m_hex;
    e.dot   = m_dot;
    e.valid = m_valid;
    e.err   = m_err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].at) begin
      checks++;
      failures++;
      $display("FAIL missing_update: got none, expected UPDATE at cycle %0d", sb[0].at);
      void'(sb.pop_front());
    end
    if (update === 1'b1) begin
      n_updates++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update: got UPDATE idx %0d at cycle %0d, expected none", upd_idx, cyc);
      end else begin
        e = sb.pop_front();
        check("upd_cycle", 32'(cyc), 32'(e.at));
        check("upd_idx",   32'(upd_idx), 32'(e.idx));
        check("upd_hex",   32'(hex_val), 32'(e.hex));
        check("upd_dot",   32'(dot), 32'(e.dot));
        check("upd_valid", 32'(dig_valid), 32'(e.valid));
        check("upd_err",   32'(err), 32'(e.err));
      end
    end
  end

  logic [3:0] scan_en  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] scan_seg [4] = '{8'hC0, 8'hF9, 8'h24, 8'hB0};
  logic [3:0] scan_nib [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
  logic       scan_dot [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int u0;
    m_hex = '0; m_dot = '0; m_valid = '0; m_err = 1'b0;
    rst = 1'b1; clr_err = 1'b0;
    drive(4'b1111, 8'hFF);
    step(3);
    check("rst_hex",    32'(hex_val), 32'h0);
    check("rst_dot",    32'(dot), 32'h0);
    check("rst_valid",  32'(dig_valid), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_updidx", 32'(upd_idx), 32'h0);
    check("rst_err",    32'(err), 32'h0);
    rst = 1'b0;
    step(2);

    // Basic decode: 5 on digit 0, dot off.
    drive(4'b1110, 8'h92);
    expect_commit(0, 0, 4'h5, 1'b0);
    step(10);

    // Scan all four digits, dot on digit 2.
    for (int i = 0; i < 4; i++) begin
      drive(scan_en[i], scan_seg[i]);
      expect_commit(i, 0, scan_nib[i], scan_dot[i]);
      step(6);
    end
    check("scan_hex",   32'(hex_val), 32'h3210);
    check("scan_dot",   32'(dot), 32'b0100);
    check("scan_valid", 32'(dig_valid), 32'hF);

    // Glitch: 1 cycle of 8, 2-cycle blip of 1, then clean 8.
    drive(4'b1101, 8'h80);
    step(1);
    drive(4'b1101, 8'hF9);
    step(2);
    drive(4'b1101, 8'h80);
    expect_commit(1, 0, 4'h8, 1'b0);
    step(8);
    // Blip of STABLE_CYCLES-1 samples never commits, and the return is a fresh episode.
    drive(4'b1101, 8'hA4);
    step(3);
    drive(4'b1101, 8'h80);
    expect_commit(1, 0, 4'h8, 1'b0);
    step(6);
    check("glitch_hex", 32'(hex_val), 32'h3280);

    // Illegal, then blank, then clear, then clear coincident with an illegal commit.
    drive(4'b0111, 8'hAA);
    expect_commit(3, 2, 4'h0, 1'b0);
    step(6);
    check("illegal_err",   32'(err), 32'h1);
    check("illegal_valid", 32'(dig_valid[3]), 32'h0);
    check("illegal_hex",   32'(hex_val[15:12]), 32'h3);
    drive(4'b0111, 8'hFF);
    expect_commit(3, 1, 4'h0, 1'b0);
    step(6);
    check("blank_err", 32'(err), 32'h1);
    drive(4'b1111, 8'hFF);
    step(2);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    m_err   = 1'b0;
    check("clr_err", 32'(err), 32'h0);
    drive(4'b0111, 8'hAA);
    expect_commit(3, 2, 4'h0, 1'b0);
    step(4);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    step(2);
    check("set_beats_clr", 32'(err), 32'h1);

    // Bus faults: two enables low, then none low.
    u0 = n_updates;
    drive(4'b1100, 8'hC0);
    step(8);
    drive(4'b1111, 8'hC0);
    step(8);
    check("bus_fault_no_update", 32'(n_updates), 32'(u0));

    // Reset mid-track at cnt=3: no commit, outputs cleared, counting restarts after release.
    drive(4'b1110, 8'h99);
    step(4);
    rst = 1'b1;
    #1;
    check("midrst_hex",   32'(hex_val), 32'h0);
    check("midrst_valid", 32'(dig_valid), 32'h0);
    check("midrst_err",   32'(err), 32'h0);
    m_hex = '0; m_dot = '0; m_valid = '0; m_err = 1'b0;
    step(1);
    rst = 1'b0;
    expect_commit(0, 0, 4'h4, 1'b0);
    step(8);
    check("final_hex",   32'(hex_val), 32'h0004);
    check("final_valid", 32'(dig_valid), 32'h1);
    check("final_dot",   32'(dot), 32'h0);

    step(2);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
